// File: rtl/pit_pkg.sv
// Shared types and constants for the PIT timer core's input-capture block.
package pit_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ARM,
    CAP_MEASURE
  } cap_state_e;

  localparam int CAP_SYNC_MIN = 2;

endpackage

// File: rtl/pit_sync_edge.sv
// Synchronizer chain for an asynchronous pulse input, followed by a rising-edge detector.
module pit_sync_edge
  import pit_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic bus_clk,
  input  logic sync_reset,
  input  logic cap_in,
  output logic cap_edge
);

  // A chain shorter than two flops is not a safe synchronizer, so clamp it.
  localparam int STAGES = (SYNC_STAGES < CAP_SYNC_MIN) ? CAP_SYNC_MIN : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge bus_clk) begin
    if (sync_reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], cap_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign cap_edge = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pit_capture.sv
// Input capture: measures the spacing of cap_in rising edges in prescaler ticks,
// latching each interval into cap_value with a sticky flag and a one-cycle interrupt.
module pit_capture
  import pit_pkg::*;
#(
  parameter int COUNT_SIZE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  bus_clk,
  input  logic                  sync_reset,
  input  logic                  capture_en,
  input  logic                  prescale_out,
  input  logic                  cap_in,
  input  logic                  cap_flg_clr,
  output logic [COUNT_SIZE-1:0] cap_value,
  output logic                  cap_flag_o,
  output logic                  ovf_flag_o,
  output logic                  cap_irq_o
);

  cap_state_e            state;
  logic                  cap_edge;
  logic [COUNT_SIZE-1:0] tick_cnt;
  logic                  ovf_pend;
  logic [COUNT_SIZE-1:0] tick_start;

  pit_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .bus_clk   (bus_clk),
    .sync_reset(sync_reset),
    .cap_in    (cap_in),
    .cap_edge  (cap_edge)
  );

  // A tick coinciding with an edge belongs to the interval that starts there.
  assign tick_start = {{(COUNT_SIZE-1){1'b0}}, prescale_out};

  always_ff @(posedge bus_clk) begin
    if (sync_reset) begin
      state      <= CAP_IDLE;
      tick_cnt   <= '0;
      ovf_pend   <= 1'b0;
      cap_value  <= '0;
      cap_flag_o <= 1'b0;
      ovf_flag_o <= 1'b0;
      cap_irq_o  <= 1'b0;
    end else if (!capture_en) begin
      state      <= CAP_IDLE;
      tick_cnt   <= '0;
      ovf_pend   <= 1'b0;
      cap_flag_o <= 1'b0;
      ovf_flag_o <= 1'b0;
      cap_irq_o  <= 1'b0;
    end else begin
      cap_irq_o <= 1'b0;
      // Cleared first so that a capture later in this block overrides the clear.
      if (cap_flg_clr) begin
        cap_flag_o <= 1'b0;
        ovf_flag_o <= 1'b0;
      end
      case (state)
        CAP_IDLE: begin
          tick_cnt <= '0;
          ovf_pend <= 1'b0;
          state    <= CAP_ARM;
        end
        CAP_ARM: begin
          if (cap_edge) begin
            tick_cnt <= tick_start;
            ovf_pend <= 1'b0;
            state    <= CAP_MEASURE;
          end
        end
        CAP_MEASURE: begin
          if (cap_edge) begin
            cap_value  <= tick_cnt;
            tick_cnt   <= tick_start;
            cap_flag_o <= 1'b1;
            if (ovf_pend) begin
              ovf_flag_o <= 1'b1;
            end
            ovf_pend   <= 1'b0;
            cap_irq_o  <= 1'b1;
          end else if (prescale_out) begin
            if (tick_cnt == '1) begin
              ovf_pend <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + COUNT_SIZE'(1);
            end
          end
        end
        default: begin
          state <= CAP_IDLE;
        end
      endcase
    end
  end

endmodule
